// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// alu_issue_ctrl : decodes one instruction per request, drives the ALU, and
//                  returns result/zero/overflow/illegal flags.
// Revision: 1.0
// ============================================================================
module alu_issue_ctrl #(
  parameter int unsigned ALU_LAT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_opcode,
  input  logic [5:0]  req_funct,
  input  logic [4:0]  req_shamt,
  input  logic [31:0] req_rs_data,
  input  logic [31:0] req_rt_data,
  input  logic [15:0] req_imm,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [4:0]  alu_ctrl,
  output logic        alu_sign,
  input  logic [31:0] alu_out,
  input  logic        alu_zero,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_ovf,
  output logic        rsp_err
);

  localparam int unsigned CNT_W = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);

  localparam logic [4:0] c_alu_and = 5'b00000;
  localparam logic [4:0] c_alu_or  = 5'b00001;
  localparam logic [4:0] c_alu_add = 5'b00010;
  localparam logic [4:0] c_alu_sub = 5'b00110;
  localparam logic [4:0] c_alu_slt = 5'b00111;
  localparam logic [4:0] c_alu_nor = 5'b01000;
  localparam logic [4:0] c_alu_xor = 5'b01001;
  localparam logic [4:0] c_alu_sll = 5'b01010;
  localparam logic [4:0] c_alu_srl = 5'b10000;
  localparam logic [4:0] c_alu_sra = 5'b10001;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OVF_NONE = 2'd0,
    OVF_ADD  = 2'd1,
    OVF_SUB  = 2'd2
  } ovf_kind_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  ovf_kind_t          ovf_kind_q, ovf_kind_d;
  logic [31:0]        alu_in1_q, alu_in1_d;
  logic [31:0]        alu_in2_q, alu_in2_d;
  logic [4:0]         alu_ctrl_q, alu_ctrl_d;
  logic               alu_sign_q, alu_sign_d;
  logic [31:0]        rsp_result_q, rsp_result_d;
  logic               rsp_zero_q, rsp_zero_d;
  logic               rsp_ovf_q, rsp_ovf_d;
  logic               rsp_err_q, rsp_err_d;

  logic               dec_legal;
  logic [31:0]        dec_in1;
  logic [31:0]        dec_in2;
  logic [4:0]         dec_ctrl;
  logic               dec_sign;
  ovf_kind_t          dec_ovf;
  logic [31:0]        imm_sext;
  logic [31:0]        imm_zext;
  logic               ovf_calc;

  assign imm_sext = {{16{req_imm[15]}}, req_imm};
  assign imm_zext = {16'b0, req_imm};

  // Decode straight from the request fields; only used on the accept edge.
  always_comb begin
    dec_legal = 1'b1;
    dec_in1   = req_rs_data;
    dec_in2   = req_rt_data;
    dec_ctrl  = c_alu_add;
    dec_sign  = 1'b0;
    dec_ovf   = OVF_NONE;
    case (req_opcode)
      6'h00: begin
        case (req_funct)
          6'h20: begin dec_ctrl = c_alu_add; dec_sign = 1'b1; dec_ovf = OVF_ADD; end
          6'h21: dec_ctrl = c_alu_add;
          6'h22: begin dec_ctrl = c_alu_sub; dec_sign = 1'b1; dec_ovf = OVF_SUB; end
          6'h23: dec_ctrl = c_alu_sub;
          6'h24: dec_ctrl = c_alu_and;
          6'h25: dec_ctrl = c_alu_or;
          6'h26: dec_ctrl = c_alu_xor;
          6'h27: dec_ctrl = c_alu_nor;
          6'h2A: begin dec_ctrl = c_alu_slt; dec_sign = 1'b1; end
          6'h2B: dec_ctrl = c_alu_slt;
          6'h00: begin dec_ctrl = c_alu_sll; dec_in1 = {27'b0, req_shamt}; end
          6'h02: begin dec_ctrl = c_alu_srl; dec_in1 = {27'b0, req_shamt}; end
          6'h03: begin dec_ctrl = c_alu_sra; dec_in1 = {27'b0, req_shamt}; end
          6'h04: begin dec_ctrl = c_alu_sll; dec_in1 = {27'b0, req_rs_data[4:0]}; end
          6'h06: begin dec_ctrl = c_alu_srl; dec_in1 = {27'b0, req_rs_data[4:0]}; end
          6'h07: begin dec_ctrl = c_alu_sra; dec_in1 = {27'b0, req_rs_data[4:0]}; end
          default: dec_legal = 1'b0;
        endcase
      end
      6'h08: begin dec_ctrl = c_alu_add; dec_in2 = imm_sext; dec_sign = 1'b1; dec_ovf = OVF_ADD; end
      6'h09: begin dec_ctrl = c_alu_add; dec_in2 = imm_sext; end
      6'h0A: begin dec_ctrl = c_alu_slt; dec_in2 = imm_sext; dec_sign = 1'b1; end
      6'h0B: begin dec_ctrl = c_alu_slt; dec_in2 = imm_sext; end
      6'h0C: begin dec_ctrl = c_alu_and; dec_in2 = imm_zext; end
      6'h0D: begin dec_ctrl = c_alu_or;  dec_in2 = imm_zext; end
      6'h0E: begin dec_ctrl = c_alu_xor; dec_in2 = imm_zext; end
      6'h0F: begin dec_ctrl = c_alu_sll; dec_in1 = 32'd16; dec_in2 = imm_zext; end
      6'h04, 6'h05: begin dec_ctrl = c_alu_sub; dec_sign = 1'b1; end
      default: dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    ovf_calc = 1'b0;
    case (ovf_kind_q)
      OVF_ADD: ovf_calc = (alu_in1_q[31] == alu_in2_q[31]) && (alu_out[31] != alu_in1_q[31]);
      OVF_SUB: ovf_calc = (alu_in1_q[31] != alu_in2_q[31]) && (alu_out[31] != alu_in1_q[31]);
      default: ovf_calc = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ovf_kind_d   = ovf_kind_q;
    alu_in1_d    = alu_in1_q;
    alu_in2_d    = alu_in2_q;
    alu_ctrl_d   = alu_ctrl_q;
    alu_sign_d   = alu_sign_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_ovf_d    = rsp_ovf_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (dec_legal) begin
            alu_in1_d  = dec_in1;
            alu_in2_d  = dec_in2;
            alu_ctrl_d = dec_ctrl;
            alu_sign_d = dec_sign;
            ovf_kind_d = dec_ovf;
            cnt_d      = CNT_W'(ALU_LAT);
            state_d    = S_ISSUE;
          end else begin
            // Illegal ops bypass the ALU and leave its operand ports untouched.
            rsp_result_d = 32'b0;
            rsp_zero_d   = 1'b0;
            rsp_ovf_d    = 1'b0;
            rsp_err_d    = 1'b1;
            state_d      = S_RESP;
          end
        end
      end
      S_ISSUE: begin
        if (cnt_q == '0) begin
          rsp_result_d = alu_out;
          rsp_zero_d   = alu_zero;
          rsp_ovf_d    = ovf_calc;
          rsp_err_d    = 1'b0;
          state_d      = S_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      ovf_kind_q   <= OVF_NONE;
      alu_in1_q    <= 32'b0;
      alu_in2_q    <= 32'b0;
      alu_ctrl_q   <= 5'b0;
      alu_sign_q   <= 1'b0;
      rsp_result_q <= 32'b0;
      rsp_zero_q   <= 1'b0;
      rsp_ovf_q    <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ovf_kind_q   <= ovf_kind_d;
      alu_in1_q    <= alu_in1_d;
      alu_in2_q    <= alu_in2_d;
      alu_ctrl_q   <= alu_ctrl_d;
      alu_sign_q   <= alu_sign_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_ovf_q    <= rsp_ovf_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign rsp_valid  = (state_q == S_RESP);
  assign alu_in1    = alu_in1_q;
  assign alu_in2    = alu_in2_q;
  assign alu_ctrl   = alu_ctrl_q;
  assign alu_sign   = alu_sign_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_ovf    = rsp_ovf_q;
  assign rsp_err    = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// tb_alu_issue_ctrl : directed + random requests against an instruction-level
//                     reference model, with a pipelined ALU of latency LAT.
// Revision: 1.0
// ============================================================================
module tb_alu_issue_ctrl;

  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [5:0]  req_opcode, req_funct;
  logic [4:0]  req_shamt;
  logic [31:0] req_rs_data, req_rt_data;
  logic [15:0] req_imm;
  logic [31:0] alu_in1, alu_in2, alu_out;
  logic [4:0]  alu_ctrl;
  logic        alu_sign, alu_zero;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero, rsp_ovf, rsp_err;

  int n_checks = 0;
  int n_err    = 0;

  alu_issue_ctrl #(.ALU_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_funct(req_funct), .req_shamt(req_shamt),
    .req_rs_data(req_rs_data), .req_rt_data(req_rt_data), .req_imm(req_imm),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctrl(alu_ctrl), .alu_sign(alu_sign),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Behavioural ALU whose output lags its operands by LAT cycles.
  function automatic logic [31:0] alu_fn(logic [31:0] a, logic [31:0] b, logic [4:0] c, logic s);
    case (c)
      5'b00000: return a & b;
      5'b00001: return a | b;
      5'b00010: return a + b;
      5'b00110: return a - b;
      5'b00111: return s ? {31'b0, ($signed(a) < $signed(b))} : {31'b0, (a < b)};
      5'b01000: return ~(a | b);
      5'b01001: return a ^ b;
      5'b01010: return b << a[4:0];
      5'b10000: return b >> a[4:0];
      5'b10001: return $signed(b) >>> a[4:0];
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  logic [31:0] alu_pipe [LAT];
  always @(posedge clk) begin
    alu_pipe[0] <= alu_fn(alu_in1, alu_in2, alu_ctrl, alu_sign);
    for (int i = LAT - 1; i > 0; i--) alu_pipe[i] <= alu_pipe[i-1];
  end
  assign alu_out  = alu_pipe[LAT-1];
  assign alu_zero = (alu_out == 32'b0);

  typedef struct {
    bit          legal;
    logic [31:0] in1, in2;
    logic [4:0]  ctrl;
    bit          sign;
    logic [31:0] res;
    bit          zero, ovf;
  } exp_t;

  function automatic bit sovf(logic [31:0] a, logic [31:0] b, bit sub);
    longint sa, sb, s, lim;
    sa = $signed(a);
    sb = $signed(b);
    s = sub ? (sa - sb) : (sa + sb);
    lim = 64'sh7FFF_FFFF;
    return (s > lim) || (s < -lim - 1);
  endfunction

  // Instruction-level reference: operands the ALU should see and the
  // architectural result each instruction should produce.
  function automatic exp_t model(logic [5:0] op, logic [5:0] fn, logic [4:0] sh,
                                 logic [31:0] rs, logic [31:0] rt, logic [15:0] imm);
    exp_t e;
    logic [31:0] se, ze;
    se = {{16{imm[15]}}, imm};
    ze = {16'h0, imm};
    e.legal = 1; e.in1 = rs; e.in2 = rt; e.ctrl = 5'b00010; e.sign = 0; e.res = 0; e.ovf = 0;
    if (op == 6'h00) begin
      case (fn)
        6'h20: begin e.ctrl = 5'b00010; e.sign = 1; e.res = rs + rt; e.ovf = sovf(rs, rt, 0); end
        6'h21: begin e.ctrl = 5'b00010; e.res = rs + rt; end
        6'h22: begin e.ctrl = 5'b00110; e.sign = 1; e.res = rs - rt; e.ovf = sovf(rs, rt, 1); end
        6'h23: begin e.ctrl = 5'b00110; e.res = rs - rt; end
        6'h24: begin e.ctrl = 5'b00000; e.res = rs & rt; end
        6'h25: begin e.ctrl = 5'b00001; e.res = rs | rt; end
        6'h26: begin e.ctrl = 5'b01001; e.res = rs ^ rt; end
        6'h27: begin e.ctrl = 5'b01000; e.res = ~(rs | rt); end
        6'h2A: begin e.ctrl = 5'b00111; e.sign = 1; e.res = ($signed(rs) < $signed(rt)) ? 1 : 0; end
        6'h2B: begin e.ctrl = 5'b00111; e.res = (rs < rt) ? 1 : 0; end
        6'h00: begin e.ctrl = 5'b01010; e.in1 = 32'(sh); e.res = rt << sh; end
        6'h02: begin e.ctrl = 5'b10000; e.in1 = 32'(sh); e.res = rt >> sh; end
        6'h03: begin e.ctrl = 5'b10001; e.in1 = 32'(sh); e.res = $signed(rt) >>> sh; end
        6'h04: begin e.ctrl = 5'b01010; e.in1 = rs % 32; e.res = rt << (rs % 32); end
        6'h06: begin e.ctrl = 5'b10000; e.in1 = rs % 32; e.res = rt >> (rs % 32); end
        6'h07: begin e.ctrl = 5'b10001; e.in1 = rs % 32; e.res = $signed(rt) >>> (rs % 32); end
        default: e.legal = 0;
      endcase
    end else begin
      case (op)
        6'h08: begin e.in2 = se; e.sign = 1; e.res = rs + se; e.ovf = sovf(rs, se, 0); end
        6'h09: begin e.in2 = se; e.res = rs + se; end
        6'h0A: begin e.ctrl = 5'b00111; e.in2 = se; e.sign = 1; e.res = ($signed(rs) < $signed(se)) ? 1 : 0; end
        6'h0B: begin e.ctrl = 5'b00111; e.in2 = se; e.res = (rs < se) ? 1 : 0; end
        6'h0C: begin e.ctrl = 5'b00000; e.in2 = ze; e.res = rs & ze; end
        6'h0D: begin e.ctrl = 5'b00001; e.in2 = ze; e.res = rs | ze; end
        6'h0E: begin e.ctrl = 5'b01001; e.in2 = ze; e.res = rs ^ ze; end
        6'h0F: begin e.ctrl = 5'b01010; e.in1 = 16; e.in2 = ze; e.res = {imm, 16'h0}; end
        6'h04, 6'h05: begin e.ctrl = 5'b00110; e.sign = 1; e.res = rs - rt; end
        default: e.legal = 0;
      endcase
    end
    e.zero = (e.res == 0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  logic [31:0] prev_in1 = 0, prev_in2 = 0;
  logic [4:0]  prev_ctrl = 0;
  logic        prev_sign = 0;

  task automatic chk_alu_ports(input string tag);
    chk({tag, "_in1"}, alu_in1, prev_in1);
    chk({tag, "_in2"}, alu_in2, prev_in2);
    chk({tag, "_ctrl"}, 32'(alu_ctrl), 32'(prev_ctrl));
    chk({tag, "_sign"}, 32'(alu_sign), 32'(prev_sign));
  endtask

  task automatic run_op(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                        input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] imm,
                        input int bp);
    exp_t e;
    logic [31:0] held;
    e = model(op, fn, sh, rs, rt, imm);
    @(negedge clk);
    req_valid = 1; req_opcode = op; req_funct = fn; req_shamt = sh;
    req_rs_data = rs; req_rt_data = rt; req_imm = imm;
    @(posedge clk); #1;
    req_valid = 0;
    req_opcode = 6'($urandom); req_funct = 6'($urandom); req_shamt = 5'($urandom);
    req_rs_data = $urandom; req_rt_data = $urandom; req_imm = 16'($urandom);
    if (e.legal) begin
      prev_in1 = e.in1; prev_in2 = e.in2; prev_ctrl = e.ctrl; prev_sign = e.sign;
      chk("acc_req_ready", 32'(req_ready), 0);
      chk("acc_rsp_valid", 32'(rsp_valid), 0);
      chk_alu_ports("issue");
      repeat (LAT) begin
        @(posedge clk); #1;
        chk("lat_rsp_valid", 32'(rsp_valid), 0);
      end
      @(posedge clk); #1;
    end
    chk("rsp_valid", 32'(rsp_valid), 1);
    chk_alu_ports("resp");
    chk("rsp_result", rsp_result, e.legal ? e.res : 32'h0);
    chk("rsp_zero", 32'(rsp_zero), e.legal ? 32'(e.zero) : 0);
    chk("rsp_ovf", 32'(rsp_ovf), e.legal ? 32'(e.ovf) : 0);
    chk("rsp_err", 32'(rsp_err), e.legal ? 0 : 1);
    held = rsp_result;
    for (int i = 0; i < bp; i++) begin
      req_valid = 1;
      @(posedge clk); #1;
      chk("bp_rsp_valid", 32'(rsp_valid), 1);
      chk("bp_req_ready", 32'(req_ready), 0);
      chk("bp_result_hold", rsp_result, held);
      chk("bp_in1_hold", alu_in1, prev_in1);
    end
    req_valid = 0;
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    chk("post_rsp_valid", 32'(rsp_valid), 0);
    chk("post_req_ready", 32'(req_ready), 1);
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 4))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] rfn [16];
    logic [5:0] iop [10];
    logic [5:0] op, fn;
    logic [31:0] rs, rt;
    rfn = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
            6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
    iop = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h04, 6'h05};

    reset = 0; req_valid = 0; rsp_ready = 0;
    req_opcode = 0; req_funct = 0; req_shamt = 0;
    req_rs_data = 0; req_rt_data = 0; req_imm = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_flags", {28'b0, rsp_zero, rsp_ovf, rsp_err, alu_sign}, 0);
    chk_alu_ports("rst");
    @(negedge clk); reset = 1;

    run_op(6'h00, 6'h20, 5'd0, 32'h7FFF_FFFF, 32'h0000_0001, 16'h0, 0);
    run_op(6'h0A, 6'h00, 5'd0, 32'hFFFF_FFFE, 32'h0, 16'h0001, 0);
    run_op(6'h0B, 6'h00, 5'd0, 32'hFFFF_FFFE, 32'h0, 16'hFFFF, 0);
    run_op(6'h00, 6'h03, 5'd4, 32'h0, 32'h8000_0000, 16'h0, 0);
    run_op(6'h00, 6'h07, 5'd0, 32'h0000_0024, 32'h8000_0000, 16'h0, 0);
    run_op(6'h0F, 6'h00, 5'd0, 32'h1111_1111, 32'h0, 16'h1234, 0);
    run_op(6'h04, 6'h00, 5'd0, 32'd5, 32'd5, 16'h0, 0);
    run_op(6'h00, 6'h22, 5'd0, 32'h8000_0000, 32'h0000_0001, 16'h0, 3);
    run_op(6'h3F, 6'h00, 5'd0, 32'h1, 32'h2, 16'h3, 1);
    run_op(6'h00, 6'h01, 5'd0, 32'h1, 32'h2, 16'h3, 0);

    for (int n = 0; n < 60; n++) begin
      int r;
      r = $urandom_range(0, 99);
      rs = rnd32();
      rt = ($urandom_range(0, 5) == 0) ? rs : rnd32();
      if (r < 45) begin
        op = 6'h00; fn = rfn[$urandom_range(0, 15)];
      end else if (r < 90) begin
        op = iop[$urandom_range(0, 9)]; fn = 6'($urandom);
      end else begin
        op = 6'($urandom); fn = 6'($urandom);
      end
      run_op(op, fn, 5'($urandom), rs, rt, 16'($urandom), $urandom_range(0, 2));
    end

    // Asynchronous reset in the middle of ISSUE.
    run_op(6'h00, 6'h25, 5'd0, 32'hA5A5_0000, 32'h0000_5A5A, 16'h0, 0);
    @(negedge clk);
    req_valid = 1; req_opcode = 6'h00; req_funct = 6'h20;
    req_rs_data = 32'h7FFF_FFFF; req_rt_data = 32'h7FFF_FFFF;
    @(posedge clk); #1;
    req_valid = 0;
    @(posedge clk); #1;
    reset = 0;
    #1;
    prev_in1 = 0; prev_in2 = 0; prev_ctrl = 0; prev_sign = 0;
    chk("arst_rsp_valid", 32'(rsp_valid), 0);
    chk("arst_req_ready", 32'(req_ready), 1);
    chk("arst_rsp_result", rsp_result, 0);
    chk("arst_rsp_flags", {29'b0, rsp_zero, rsp_ovf, rsp_err}, 0);
    chk_alu_ports("arst");
    @(negedge clk); reset = 1;
    repeat (LAT + 3) begin
      @(posedge clk); #1;
      chk("arst_no_stale_valid", 32'(rsp_valid), 0);
      chk("arst_idle_ready", 32'(req_ready), 1);
    end
    run_op(6'h00, 6'h21, 5'd0, 32'h0000_0010, 32'h0000_0020, 16'h0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
